// File: rtl/alu_mac_pipe_if.sv
// Operand/result bus for alu_mac_pipe: valid/ready operand side and valid/ready result side.
interface alu_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int DW = 18,
  parameter int PW = 48
) ();
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    sel;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic [PW-1:0] c;
  logic [DW-1:0] d;
  logic          carryin;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;

  // Operand sequencer / result consumer side
  modport master (
    output in_valid, sel, a, b, c, d, carryin, out_ready,
    input  in_ready, out_valid, p
  );

  // ALU side
  modport slave (
    input  in_valid, sel, a, b, c, d, carryin, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/alu_mac_pipe.sv
// Pipelined multiply-accumulate ALU. Operands are captured at the accept edge,
// then pass through pre-add, multiply and post-add stages; the post-add stage
// writes the result/accumulator register p. The whole pipe advances together
// whenever the output register is empty or being drained.
module alu_mac_pipe #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int DW = 18,
  parameter int PW = 48
) (
  input  logic          clk,
  input  logic          rst,
  alu_mac_pipe_if.slave bus
);

  localparam int PRE_W  = ((AW > DW) ? AW : DW) + 1;
  localparam int PROD_W = PRE_W + BW;
  localparam int MW     = (PROD_W > PW) ? PROD_W : PW;

  typedef enum logic [2:0] {
    OP_MAC    = 3'b000,
    OP_MUL    = 3'b001,
    OP_ADD    = 3'b010,
    OP_PREMAC = 3'b011,
    OP_ACC    = 3'b100,
    OP_SUB    = 3'b101,
    OP_LOAD   = 3'b110,
    OP_CLR    = 3'b111
  } op_e;

  logic adv;
  logic out_valid_q;
  logic [PW-1:0] p_q;
  logic [PW-1:0] p_next;

  logic v0, v1, v2;

  op_e           sel0;
  logic [AW-1:0] a0;
  logic [BW-1:0] b0;
  logic [PW-1:0] c0;
  logic [DW-1:0] d0;
  logic          cin0;

  op_e            sel1;
  logic [PRE_W-1:0] pre1;
  logic [BW-1:0]  b1;
  logic [PW-1:0]  c1;
  logic           cin1;

  op_e           sel2;
  logic [PW-1:0] mid2;
  logic [PW-1:0] c2;
  logic          cin2;

  logic [PRE_W-1:0] pre_comb;
  logic [PW-1:0]    prod_pw;
  logic [PW-1:0]    mid_comb;

  assign adv           = !out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;

  // Pre-adder only folds d in for the two modes that use it
  assign pre_comb = (sel0 == OP_ADD || sel0 == OP_PREMAC)
                    ? PRE_W'(a0) + PRE_W'(d0)
                    : PRE_W'(a0);

  // Full-width product, then fitted to PW; the add-only mode bypasses the multiplier
  assign prod_pw  = PW'(MW'(pre1) * MW'(b1));
  assign mid_comb = (sel1 == OP_ADD) ? PW'(pre1) : prod_pw;

  // Post-add selection; accumulate modes read the current p, so chains need no stall
  always_comb begin
    p_next = p_q;
    case (sel2)
      OP_MAC:    p_next = mid2 + c2;
      OP_MUL:    p_next = mid2;
      OP_ADD:    p_next = mid2;
      OP_PREMAC: p_next = mid2 + c2 + {{(PW-1){1'b0}}, cin2};
      OP_ACC:    p_next = p_q + mid2;
      OP_SUB:    p_next = p_q - mid2;
      OP_LOAD:   p_next = c2;
      OP_CLR:    p_next = '0;
      default:   p_next = p_q;
    endcase
  end

  // Stage valids, output valid and result register; reset discards all in-flight work
  always_ff @(posedge clk) begin
    if (rst) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else if (adv) begin
      v0          <= bus.in_valid;
      v1          <= v0;
      v2          <= v1;
      out_valid_q <= v2;
      if (v2) begin
        p_q <= p_next;
      end
    end
  end

  // Stage data moves with the valids; contents of bubble slots are don't-care
  always_ff @(posedge clk) begin
    if (adv) begin
      sel0 <= op_e'(bus.sel);
      a0   <= bus.a;
      b0   <= bus.b;
      c0   <= bus.c;
      d0   <= bus.d;
      cin0 <= bus.carryin;

      sel1 <= sel0;
      pre1 <= pre_comb;
      b1   <= b0;
      c1   <= c0;
      cin1 <= cin0;

      sel2 <= sel1;
      mid2 <= mid_comb;
      c2   <= c1;
      cin2 <= cin1;
    end
  end

endmodule

// File: tb/tb_alu_mac_pipe.sv
// Bench for alu_mac_pipe: directed operand sets with hand-computed results,
// queued on issue and matched by an output monitor in transfer order.
module tb_alu_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int DW = 18;
  localparam int PW = 48;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_mac_pipe_if #(.AW(AW), .BW(BW), .DW(DW), .PW(PW)) bus ();

  alu_mac_pipe #(.AW(AW), .BW(BW), .DW(DW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [PW-1:0] p;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Edge counter used to measure accept-to-output latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pops the expected result whenever a result transfers out
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got p=%0d expected no output", bus.p);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result", bus.p, mon_e.p);
        if (mon_e.lat) checkOutput("latency", PW'(cyc - mon_e.acc), 48'd3);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] s, input logic [AW-1:0] a, input logic [BW-1:0] b,
                               input logic [PW-1:0] c, input logic [DW-1:0] d, input logic cin,
                               input logic [PW-1:0] exp, input bit lat);
    int n = 0;
    bus.sel      = s;
    bus.a        = a;
    bus.b        = b;
    bus.c        = c;
    bus.d        = d;
    bus.carryin  = cin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end else begin
      sb.push_back('{exp, cyc + 1, lat});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sel       = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.d         = '0;
    bus.carryin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, with downstream not ready
    @(negedge clk);
    checkOutput("reset_out_valid", bus.out_valid, 48'd0);
    checkOutput("reset_p", bus.p, 48'd0);
    checkOutput("reset_in_ready", bus.in_ready, 48'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    $display("[TB] T1 latency");
    applyStimulus(3'b000, 18'd3, 18'd5, 48'd7, 18'd0, 1'b0, 48'd22, 1'b1);
    waitDrain();

    $display("[TB] T2 modes");
    applyStimulus(3'b011, 18'd2, 18'd10, 48'd1, 18'd4, 1'b1, 48'd62, 1'b1);
    applyStimulus(3'b010, 18'd2, 18'd10, 48'd0, 18'd4, 1'b0, 48'd6, 1'b1);
    applyStimulus(3'b001, 18'h20000, 18'h20000, 48'd0, 18'd0, 1'b0, 48'h4_0000_0000, 1'b1);
    applyStimulus(3'b000, 18'd3, 18'd5, 48'd7, 18'd100, 1'b1, 48'd22, 1'b1);
    waitDrain();

    $display("[TB] T3 accumulate chain");
    applyStimulus(3'b110, 18'd0, 18'd0, 48'd100, 18'd0, 1'b0, 48'd100, 1'b1);
    applyStimulus(3'b100, 18'd1, 18'd5, 48'd0, 18'd0, 1'b0, 48'd105, 1'b1);
    applyStimulus(3'b100, 18'd1, 18'd5, 48'd0, 18'd0, 1'b0, 48'd110, 1'b1);
    applyStimulus(3'b100, 18'd1, 18'd5, 48'd0, 18'd0, 1'b0, 48'd115, 1'b1);
    applyStimulus(3'b100, 18'd1, 18'd5, 48'd0, 18'd0, 1'b0, 48'd120, 1'b1);
    applyStimulus(3'b101, 18'd200, 18'd1, 48'd0, 18'd0, 1'b0, 48'hFFFF_FFFF_FFB0, 1'b1);
    applyStimulus(3'b111, 18'd7, 18'd7, 48'd7, 18'd7, 1'b1, 48'd0, 1'b1);
    waitDrain();

    $display("[TB] T6 wrap");
    applyStimulus(3'b000, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, 18'd0, 1'b0, 48'h000F_FFF8_0000, 1'b1);
    waitDrain();

    $display("[TB] T4 backpressure");
    applyStimulus(3'b000, 18'd1, 18'd2, 48'd1, 18'd0, 1'b0, 48'd3, 1'b0);
    applyStimulus(3'b000, 18'd2, 18'd2, 48'd1, 18'd0, 1'b0, 48'd5, 1'b0);
    applyStimulus(3'b000, 18'd3, 18'd2, 48'd1, 18'd0, 1'b0, 48'd7, 1'b0);
    applyStimulus(3'b000, 18'd4, 18'd2, 48'd1, 18'd0, 1'b0, 48'd9, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'b000;
    bus.a         = 18'd500;
    bus.b         = 18'd500;
    bus.c         = 48'd0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_in_ready", bus.in_ready, 48'd0);
      checkOutput("stall_out_valid", bus.out_valid, 48'd1);
      checkOutput("stall_p", bus.p, 48'd3);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(3'b000, 18'd5, 18'd2, 48'd1, 18'd0, 1'b0, 48'd11, 1'b0);
    applyStimulus(3'b000, 18'd6, 18'd2, 48'd1, 18'd0, 1'b0, 48'd13, 1'b0);
    waitDrain();

    $display("[TB] T5 reset mid-operation");
    applyStimulus(3'b000, 18'd9, 18'd9, 48'd0, 18'd0, 1'b0, 48'd81, 1'b0);
    applyStimulus(3'b000, 18'd9, 18'd9, 48'd0, 18'd0, 1'b0, 48'd81, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_out_valid", bus.out_valid, 48'd0);
    checkOutput("midreset_p", bus.p, 48'd0);
    checkOutput("midreset_in_ready", bus.in_ready, 48'd1);
    repeat (8) @(negedge clk);
    checkOutput("midreset_p_after", bus.p, 48'd0);
    @(posedge clk);
    #1;
    applyStimulus(3'b000, 18'd3, 18'd5, 48'd7, 18'd0, 1'b0, 48'd22, 1'b1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
